// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches under a
// DEPTH credit, buffers returned words with their PCs and hands them to ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        id_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W    = CNT_W + 1;
  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } slot_t;

  slot_t mem [DEPTH];

  logic [31:0]      fetch_pc, fetch_pc_n;
  logic [31:0]      resp_pc, resp_pc_n;
  logic [CNT_W-1:0] inflight, inflight_n;
  logic [CNT_W-1:0] drop, drop_n;
  logic [CNT_W-1:0] count, count_n, avail;
  logic [PTR_W-1:0] rd_ptr, rd_n, wr_ptr, wr_n;
  logic             req_en, req_en_n;
  logic             inst_valid_n;
  logic [31:0]      inst_n, inst_pc_n;
  logic [31:0]      target;
  logic             accept, push, pop;

  assign target         = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req_valid = req_en & ~redirect_valid;
  assign imem_req_addr  = fetch_pc;

  // Next-state: credit, drop accounting, FIFO bookkeeping and output staging
  always_comb begin
    accept     = imem_req_valid & imem_req_ready;
    push       = imem_resp_valid & ~redirect_valid & (drop == '0);
    pop        = inst_valid & id_ready & ~redirect_valid;

    inflight_n = inflight;
    if (accept && !imem_resp_valid)
      inflight_n = inflight + CNT_W'(1);
    else if (!accept && imem_resp_valid)
      inflight_n = inflight - CNT_W'(1);

    drop_n = drop;
    if (redirect_valid)
      drop_n = inflight_n;
    else if (imem_resp_valid && drop != '0)
      drop_n = drop - CNT_W'(1);

    avail        = count - CNT_W'(pop);
    count_n      = avail + CNT_W'(push);
    rd_n         = rd_ptr + PTR_W'(pop);
    wr_n         = wr_ptr + PTR_W'(push);
    fetch_pc_n   = accept ? fetch_pc + 32'd4 : fetch_pc;
    resp_pc_n    = push ? resp_pc + 32'd4 : resp_pc;
    inst_valid_n = (avail != '0);
    inst_n       = inst;
    inst_pc_n    = inst_pc;

    // Output register only ever samples entries written at an earlier edge
    if (avail != '0) begin
      inst_n    = mem[rd_n].word;
      inst_pc_n = mem[rd_n].pc;
    end

    if (redirect_valid) begin
      fetch_pc_n   = target;
      resp_pc_n    = target;
      count_n      = '0;
      rd_n         = '0;
      wr_n         = '0;
      inst_valid_n = 1'b0;
      inst_n       = inst;
      inst_pc_n    = inst_pc;
    end

    req_en_n = (SUM_W'(count_n) + SUM_W'(inflight_n)) < SUM_W'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc   <= START_PC;
      resp_pc    <= START_PC;
      inflight   <= '0;
      drop       <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      req_en     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      fetch_pc   <= fetch_pc_n;
      resp_pc    <= resp_pc_n;
      inflight   <= inflight_n;
      drop       <= drop_n;
      count      <= count_n;
      rd_ptr     <= rd_n;
      wr_ptr     <= wr_n;
      req_en     <= req_en_n;
      inst_valid <= inst_valid_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
    end
  end

  // Word storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {resp_pc, imem_resp_data};
  end

endmodule
